// File: rtl/conv_sequencer.sv
// Segmented sparse-convolution sequencer: walks rj segment counts and signed
// coefficient delays, accumulates samples per segment, halves into acc per segment.
module conv_sequencer #(
  parameter int NSEG  = 16,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic             start,
  input  logic [7:0]       data_wr_ptr,
  output logic [3:0]       rj_addr,
  input  logic [7:0]       rj_data,
  output logic [8:0]       coeff_addr,
  input  logic [8:0]       coeff_data,
  output logic [7:0]       data_addr,
  input  logic [15:0]      data_data,
  output logic             busy,
  output logic [ACC_W-1:0] y_out,
  output logic             y_valid
);
  localparam int JW = $clog2(NSEG + 1);

  typedef enum logic [2:0] {
    IDLE, RJ_RD, RJ_LAT, COEF_RD, DATA_RD, ACCUM, SEG_END, DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [7:0]               base_q, base_d;
  logic [JW-1:0]            j_q, j_d;
  logic [8:0]               cptr_q, cptr_d;
  logic [7:0]               cnt_q, cnt_d;
  logic                     sign_q, sign_d;
  logic signed [ACC_W-1:0]  u_q, u_d, acc_q, acc_d;
  logic [ACC_W-1:0]         y_q, y_d;
  logic [15:0]              hold_q, hold_d;
  logic                     fresh_q;

  // Memory data only lines up with its address on the first cycle in a consuming
  // state; if frozen there, the address drops, so the word is captured into hold_q.
  logic [7:0]              rj_v;
  logic [8:0]              cf_v;
  logic [15:0]             dd_v;
  logic signed [ACC_W-1:0] dx, sum;

  assign rj_v = fresh_q ? rj_data    : hold_q[7:0];
  assign cf_v = fresh_q ? coeff_data : hold_q[8:0];
  assign dd_v = fresh_q ? data_data  : hold_q;
  assign dx   = {{(ACC_W-16){dd_v[15]}}, dd_v};
  assign sum  = acc_q + u_q;

  assign rj_addr    = (state_q == RJ_RD)   ? 4'(j_q) : 4'd0;
  assign coeff_addr = (state_q == COEF_RD) ? cptr_q  : 9'd0;
  assign data_addr  = (state_q == DATA_RD) ? (base_q - cf_v[7:0]) : 8'd0;
  assign busy       = (state_q != IDLE);
  assign y_valid    = (state_q == DONE) && en && !clear;
  assign y_out      = y_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    j_d     = j_q;
    cptr_d  = cptr_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    u_d     = u_q;
    acc_d   = acc_q;
    y_d     = y_q;
    hold_d  = hold_q;
    if (fresh_q && !en) begin
      case (state_q)
        RJ_LAT:  hold_d = {8'd0, rj_data};
        DATA_RD: hold_d = {7'd0, coeff_data};
        ACCUM:   hold_d = data_data;
        default: hold_d = hold_q;
      endcase
    end
    if (clear) begin
      state_d = IDLE;
      j_d     = '0;
      cptr_d  = '0;
      cnt_d   = '0;
      u_d     = '0;
      acc_d   = '0;
    end else if (en) begin
      case (state_q)
        IDLE: if (start) begin
          base_d  = data_wr_ptr;
          j_d     = '0;
          cptr_d  = '0;
          acc_d   = '0;
          u_d     = '0;
          state_d = RJ_RD;
        end
        RJ_RD:   state_d = RJ_LAT;
        RJ_LAT: begin
          cnt_d   = rj_v;
          state_d = (rj_v == 8'd0) ? SEG_END : COEF_RD;
        end
        COEF_RD: state_d = DATA_RD;
        DATA_RD: begin
          sign_d  = cf_v[8];
          state_d = ACCUM;
        end
        ACCUM: begin
          u_d     = sign_q ? (u_q - dx) : (u_q + dx);
          cptr_d  = cptr_q + 9'd1;
          cnt_d   = cnt_q - 8'd1;
          state_d = (cnt_q == 8'd1) ? SEG_END : COEF_RD;
        end
        SEG_END: begin
          acc_d = sum >>> 1;
          u_d   = '0;
          j_d   = j_q + JW'(1);
          if (j_q == JW'(NSEG - 1)) begin
            state_d = DONE;
            y_d     = acc_d;
          end else begin
            state_d = RJ_RD;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      j_q     <= '0;
      cptr_q  <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      u_q     <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      hold_q  <= '0;
      fresh_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      j_q     <= j_d;
      cptr_q  <= cptr_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      u_q     <= u_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      hold_q  <= hold_d;
      fresh_q <= en;
    end
  end
endmodule

// File: tb/tb_conv_sequencer.sv
// Directed bench for conv_sequencer with registered-read memory models.
module tb_conv_sequencer;
  logic        clk = 1'b0, reset_n = 1'b0, clear = 1'b0, en = 1'b1, start = 1'b0;
  logic [7:0]  data_wr_ptr = 8'd0;
  logic [3:0]  rj_addr;
  logic [7:0]  rj_data;
  logic [8:0]  coeff_addr, coeff_data;
  logic [7:0]  data_addr;
  logic [15:0] data_data;
  logic        busy, y_valid;
  logic [39:0] y_out;

  conv_sequencer dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .en(en), .start(start),
    .data_wr_ptr(data_wr_ptr), .rj_addr(rj_addr), .rj_data(rj_data),
    .coeff_addr(coeff_addr), .coeff_data(coeff_data), .data_addr(data_addr),
    .data_data(data_data), .busy(busy), .y_out(y_out), .y_valid(y_valid)
  );

  always #5 clk = ~clk;

  logic [7:0]  rj_mem [16];
  logic [8:0]  cf_mem [512];
  logic [15:0] d_mem  [256];
  always @(posedge clk) begin
    rj_data    <= rj_mem[rj_addr];
    coeff_data <= cf_mem[coeff_addr];
    data_data  <= d_mem[data_addr];
  end

  int passed = 0, total = 0;
  logic [8:0]  clog [0:2047];
  logic [7:0]  dlog [0:2047];
  int          vcyc, nval;
  logic [39:0] vy, yprev;
  logic        cnz;
  logic [7:0]  base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clr_mem();
    for (int i = 0; i < 16; i++)  rj_mem[i] = 8'd0;
    for (int i = 0; i < 512; i++) cf_mem[i] = 9'd0;
    for (int i = 0; i < 256; i++) d_mem[i]  = 16'd0;
  endtask

  // Called at a negedge; that cycle is cycle 0 (start accepted at its closing edge).
  task automatic op(input string tag, input int exp_lat, input logic [39:0] exp_y,
                    input int frz_at, input int frz_len, input int clr_at,
                    input int st2_at, input int budget);
    yprev = y_out;
    en = 1'b1; data_wr_ptr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0; data_wr_ptr = ~base;
    vcyc = -1; nval = 0; cnz = 1'b0; vy = '0;
    for (int k = 1; k <= budget; k++) begin
      en    = !(k >= frz_at && k < frz_at + frz_len);
      clear = (k == clr_at);
      start = (k == st2_at);
      #1;
      clog[k] = coeff_addr;
      dlog[k] = data_addr;
      if (coeff_addr != 9'd0) cnz = 1'b1;
      if (y_valid) begin
        nval++;
        if (vcyc < 0) begin vcyc = k; vy = y_out; end
      end
      if (clr_at > 0 && k == clr_at + 1) chk({tag, "_busy_after_clear"}, busy, 0);
      @(negedge clk);
    end
    en = 1'b1; clear = 1'b0; start = 1'b0;
    if (clr_at > 0) begin
      chk({tag, "_no_valid"}, nval, 0);
      chk({tag, "_y_held"}, y_out, yprev);
    end else begin
      chk({tag, "_lat"}, vcyc, exp_lat);
      chk({tag, "_y"}, vy, exp_y);
      chk({tag, "_one_pulse"}, nval, 1);
    end
  endtask

  initial begin
    clr_mem();
    d_mem[0] = 16'h0123;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_valid", y_valid, 0);
    chk("rst_y", y_out, 0);
    chk("rst_addrs", {rj_addr, coeff_addr, data_addr}, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // All-zero rj: 16 segments of 3 cycles, no coefficient fetches
    base = 8'h10;
    op("zero_rj", 49, 40'd0, 0, 0, 0, 0, 60);
    chk("zero_rj_no_coeff_addr", cnz, 0);

    // One tap in the last segment; a second start mid-op is ignored
    rj_mem[15] = 8'd1; d_mem[8'h10] = 16'h1000;
    op("last_seg", 52, 40'd2048, 0, 0, 0, 5, 60);
    chk("last_seg_daddr", dlog[49], 8'h10);

    // Subtracted tap in the first segment, then 16 floor halvings
    rj_mem[15] = 8'd0; rj_mem[0] = 8'd1; cf_mem[0] = 9'h100; d_mem[8'h10] = 16'h4000;
    op("neg_floor", 52, 40'hFF_FFFF_FFFF, 0, 0, 0, 0, 60);

    // Data address wrap: 2 - 5 = 253
    clr_mem(); d_mem[0] = 16'h0123;
    rj_mem[15] = 8'd1; cf_mem[0] = 9'h005; base = 8'd2; d_mem[253] = 16'hFED4;
    op("daddr_wrap", 52, -40'sd150, 0, 0, 0, 0, 60);
    chk("daddr_wrap_addr", dlog[49], 8'd253);

    // Freeze 5 cycles while in ACCUM (data address drops meanwhile)
    clr_mem(); d_mem[0] = 16'h0123;
    rj_mem[15] = 8'd1; base = 8'h10; d_mem[8'h10] = 16'h1000;
    op("frz_accum", 57, 40'd2048, 50, 5, 0, 0, 65);

    // Freeze 3 cycles in the second DATA_RD of a 2-tap segment
    rj_mem[15] = 8'd2; cf_mem[1] = 9'h005; base = 8'd2;
    d_mem[2] = 16'd1000; d_mem[253] = 16'hFED4;
    op("frz_data", 58, 40'd350, 52, 3, 0, 0, 65);
    chk("frz_data_addr_first", dlog[52], 8'd253);
    chk("frz_data_addr_held", dlog[55], 8'd253);

    // Clear in cycle 10 aborts with no result
    op("clear", 0, 40'd0, 0, 0, 10, 0, 60);

    // Asynchronous reset in the middle of ACCUM (cycle 50)
    rj_mem[15] = 8'd1; cf_mem[0] = 9'h000; cf_mem[1] = 9'h000; base = 8'h10;
    d_mem[8'h10] = 16'h1000;
    data_wr_ptr = base; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (49) @(negedge clk);
    #1 chk("mid_busy", busy, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_valid", y_valid, 0);
    chk("arst_y", y_out, 0);
    chk("arst_daddr", data_addr, 0);
    @(negedge clk);
    reset_n = 1'b1;
    nval = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (y_valid || busy) nval++;
    end
    chk("post_rst_idle", nval, 0);

    // Coefficient pointer wrap: 513 taps total, ends ...,510,511,0
    clr_mem();
    rj_mem[0] = 8'd255; rj_mem[1] = 8'd255; rj_mem[2] = 8'd3;
    base = 8'h10; d_mem[8'h10] = 16'h4000;
    op("cptr_wrap", 1588, 40'd194, 0, 0, 0, 0, 1600);
    chk("cptr_wrap_510", clog[1539], 9'd510);
    chk("cptr_wrap_511", clog[1542], 9'd511);
    chk("cptr_wrap_0", clog[1545], 9'd0);
    chk("cptr_wrap_first", clog[771], 9'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/conv_sequencer.md
CONV_SEQUENCER -- requirements
Module: conv_sequencer

Interface
REQ-001 Parameter NSEG, default 16: number of rj segments per output sample.
REQ-002 Parameter ACC_W, default 40: accumulator and output width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; reset_n in 1, asynchronous active-low reset.
REQ-004 clear in 1: synchronous abort; returns the block to IDLE.
REQ-005 en in 1: high lets the FSM advance; low freezes all state and registers.
REQ-006 start in 1: single-cycle request to compute one output sample.
REQ-007 data_wr_ptr in 8: data-memory address of the newest sample, x(n).
REQ-008 rj_addr out 4: rj memory read address.
REQ-009 rj_data in 8: rj word, unsigned coefficient count for the segment.
REQ-010 coeff_addr out 9: coefficient memory read address.
REQ-011 coeff_data in 9: coefficient word; bit8 is the sign (1 = subtract); bits 7:0 are the delay k.
REQ-012 data_addr out 8: data memory read address.
REQ-013 data_data in 16: signed sample.
REQ-014 busy out 1: high in any state other than IDLE.
REQ-015 y_out out ACC_W: last completed result, signed, held between completions.
REQ-016 y_valid out 1: one-cycle pulse when y_out updates.

Function
REQ-017 All memories SHALL have a one-cycle read latency: an address driven in cycle c returns data valid in cycle c+1.
REQ-018 Address outputs SHALL be combinational from the state and registers, and SHALL be 0 outside their issuing state.
REQ-019 The FSM states SHALL be IDLE, RJ_RD, RJ_LAT, COEF_RD, DATA_RD, ACCUM, SEG_END and DONE.
REQ-020 IDLE: on start=1, latch base=data_wr_ptr, set j=0, cptr=0, acc=0, u=0, and go to RJ_RD.
REQ-021 RJ_RD: drive rj_addr=j; go to RJ_LAT.
REQ-022 RJ_LAT: latch cnt=rj_data; if cnt=0 go to SEG_END, else go to COEF_RD.
REQ-023 COEF_RD: drive coeff_addr=cptr; go to DATA_RD.
REQ-024 DATA_RD: drive data_addr=(base - coeff_data[7:0]) mod 256; latch sign=coeff_data[8]; go to ACCUM.
REQ-025 ACCUM: if sign=1, u = u - sext(data_data); else u = u + sext(data_data); then cptr=cptr+1 (9-bit wrap), cnt=cnt-1.
REQ-026 ACCUM exit: if the new cnt=0 go to SEG_END, else go to COEF_RD.
REQ-027 SEG_END: acc = (acc + u) >>> 1 (arithmetic shift, floor); u=0; j=j+1; if j reaches NSEG go to DONE, else go to RJ_RD.
REQ-028 DONE: y_out=acc; y_valid=1 for exactly this cycle; go to IDLE.
REQ-029 Arithmetic: u and acc are ACC_W-bit signed; samples are sign-extended; no saturation.
REQ-030 Latency: with start accepted in cycle 0, y_valid SHALL assert in cycle 1 + sum over j of (3 + 3*rj[j]), with en held high.
REQ-031 The coefficient pointer SHALL continue across segments and SHALL wrap from 511 to 0.
REQ-032 The data address SHALL wrap modulo 256.
REQ-033 start while busy=1 SHALL be ignored, with no queuing.
REQ-034 clear SHALL take priority over start and en: next state IDLE, j/cptr/cnt/u/acc = 0, y_out unchanged, no y_valid.
REQ-035 clear and start in the same cycle: clear wins; start is dropped.
REQ-036 en=0 SHALL hold the state, all registers and the address outputs; y_valid SHALL stay 0 while frozen, and the latency in REQ-030 extends by the frozen cycles.
REQ-037 If data_wr_ptr changes during an operation, it SHALL have no effect until the next start.

Reset
REQ-038 While reset_n=0, the block SHALL asynchronously force state=IDLE and busy=0, y_valid=0, y_out=0.
REQ-039 While reset_n=0, all addresses and internal registers SHALL be 0.
REQ-040 Reset deassertion mid-operation SHALL leave the block in IDLE; no partial result is ever emitted.

Verification
REQ-041 Reset check: assert reset_n=0 mid-ACCUM -> busy=0, y_out=0, y_valid=0 immediately, without waiting for a clock edge.
REQ-042 All rj=0, start at cycle 0 -> y_valid at cycle 49, y_out=0, coeff_addr never nonzero.
REQ-043 rj[15]=1, others 0; coeff[0]=0x000; base=0x10; data[0x10]=0x1000 -> data_addr=0x10, y_out=2048 at cycle 52.
REQ-044 rj[0]=1, others 0; coeff[0]=0x100; data[base]=0x4000 -> y_out=-1 (floor of -16384>>>16) at cycle 52.
REQ-045 Wrap check: base=2 with coeff k=5 -> data_addr=253; rj sum=513 -> coeff_addr sequence ends ...,511,0.
REQ-046 Control check: clear in cycle 10 of an operation -> IDLE next cycle, y_out unchanged, no y_valid; start during busy -> ignored; en low for 5 cycles -> y_valid delayed by 5 cycles with identical y_out.
